// File: rtl/sobel_pkg.sv
// sobel_pkg: shared constants and helpers for the Sobel/VGA pipeline.
//   SOBEL_LAT       - pixel strobes from window sample to output
//   SOBEL_DEF_PIX_W - default pixel / magnitude width
//   sobel_mode_e    - output mode select (grayscale / binary threshold)
//   sobel_grad_w()  - signed gradient width for a given pixel width
package sobel_pkg;

    localparam int unsigned SOBEL_LAT       = 4;
    localparam int unsigned SOBEL_DEF_PIX_W = 8;

    typedef enum logic {
        MODE_GRAY   = 1'b0,
        MODE_THRESH = 1'b1
    } sobel_mode_e;

    // Each gradient term sums to at most 4*(2^PIX_W-1), so 2 magnitude bits
    // plus a sign bit cover every case without overflow.
    function automatic int unsigned sobel_grad_w(input int unsigned pix_w);
        return pix_w + 3;
    endfunction

endpackage

// File: rtl/sobel_grad.sv
// sobel_grad: Sobel gradient stages S1-S2.
//   S1 registers signed gx/gy from the 3x3 window, S2 registers |gx|/|gy|.
//   Ports:
//     i_clk            clock
//     i_rst            synchronous active-low reset
//     i_en             stage load enable (pixel strobe)
//     i_p0..i_p8       window pixels, row-major, centre omitted
//     o_abs_gx/o_abs_gy  unsigned gradient magnitudes, PIX_W+2 bits
module sobel_grad
    import sobel_pkg::*;
#(
    parameter int unsigned PIX_W = SOBEL_DEF_PIX_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [PIX_W-1:0] i_p0,
    input  logic [PIX_W-1:0] i_p1,
    input  logic [PIX_W-1:0] i_p2,
    input  logic [PIX_W-1:0] i_p3,
    input  logic [PIX_W-1:0] i_p5,
    input  logic [PIX_W-1:0] i_p6,
    input  logic [PIX_W-1:0] i_p7,
    input  logic [PIX_W-1:0] i_p8,
    output logic [PIX_W+1:0] o_abs_gx,
    output logic [PIX_W+1:0] o_abs_gy
);

    localparam int unsigned GW = sobel_grad_w(PIX_W);
    localparam int unsigned AW = PIX_W + 2;

    logic signed [GW-1:0] w_gx;
    logic signed [GW-1:0] w_gy;
    logic signed [GW-1:0] r_gx;
    logic signed [GW-1:0] r_gy;
    logic [AW-1:0]        r_agx;
    logic [AW-1:0]        r_agy;

    function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
        return $signed({3'b000, p});
    endfunction

    assign w_gx = (ext(i_p2) + (ext(i_p5) <<< 1) + ext(i_p8))
                - (ext(i_p0) + (ext(i_p3) <<< 1) + ext(i_p6));
    assign w_gy = (ext(i_p6) + (ext(i_p7) <<< 1) + ext(i_p8))
                - (ext(i_p0) + (ext(i_p1) <<< 1) + ext(i_p2));

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_gx  <= '0;
            r_gy  <= '0;
            r_agx <= '0;
            r_agy <= '0;
        end else if (i_en) begin
            r_gx  <= w_gx;
            r_gy  <= w_gy;
            // Magnitude never exceeds 4*(2^PIX_W-1), so dropping the sign bit is lossless.
            r_agx <= AW'(r_gx[GW-1] ? -r_gx : r_gx);
            r_agy <= AW'(r_gy[GW-1] ? -r_gy : r_gy);
        end
    end

    assign o_abs_gx = r_agx;
    assign o_abs_gy = r_agy;

endmodule

// File: rtl/sobel_vga_pipe.sv
// sobel_vga_pipe: Sobel edge magnitude to VGA colour, with pixel-rate divider.
//   Ports:
//     xclk, rst            clock; synchronous active-low reset
//     pix_en               one-cycle pixel strobe pacing the upstream reader
//     pix_0..pix_8         3x3 window (centre unused)
//     in_hs/in_vs/in_de    syncs (active-low) and active-video flag
//     mode, thresh         0 = grayscale magnitude, 1 = binary threshold
//     xrgb, xhs, xvs       colour {R,G,B} and syncs, delay-matched
//     edge_count           per-frame edge count (only with SOBEL_EDGE_COUNT_EN)
//   Optional feature macro: SOBEL_EDGE_COUNT_EN.
module sobel_vga_pipe
    import sobel_pkg::*;
#(
    parameter int unsigned PIX_W   = SOBEL_DEF_PIX_W,
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CH_BITS = 2
) (
    input  logic                 xclk,
    input  logic                 rst,
    output logic                 pix_en,
    input  logic [PIX_W-1:0]     pix_0,
    input  logic [PIX_W-1:0]     pix_1,
    input  logic [PIX_W-1:0]     pix_2,
    input  logic [PIX_W-1:0]     pix_3,
    input  logic [PIX_W-1:0]     pix_5,
    input  logic [PIX_W-1:0]     pix_6,
    input  logic [PIX_W-1:0]     pix_7,
    input  logic [PIX_W-1:0]     pix_8,
    input  logic                 in_hs,
    input  logic                 in_vs,
    input  logic                 in_de,
    input  logic                 mode,
    input  logic [PIX_W-1:0]     thresh,
    output logic [3*CH_BITS-1:0] xrgb,
    output logic                 xhs,
    output logic                 xvs
`ifdef SOBEL_EDGE_COUNT_EN
    ,
    output logic [19:0]          edge_count
`endif
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam int unsigned SW = PIX_W + 3;

    // ---------------- divider ----------------
    logic [DIV_W-1:0] r_div_cnt;
    logic             r_pix_en;

    always_ff @(posedge xclk) begin
        if (!rst) begin
            r_div_cnt <= '0;
            r_pix_en  <= 1'b0;
        end else begin
            r_pix_en  <= (r_div_cnt == DIV_LAST);
            r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DIV_W'(1);
        end
    end

    assign pix_en = r_pix_en;

    // ---------------- S1-S2 ----------------
    logic [PIX_W+1:0] w_agx;
    logic [PIX_W+1:0] w_agy;

    sobel_grad #(
        .PIX_W(PIX_W)
    ) u_grad (
        .i_clk    (xclk),
        .i_rst    (rst),
        .i_en     (r_pix_en),
        .i_p0     (pix_0),
        .i_p1     (pix_1),
        .i_p2     (pix_2),
        .i_p3     (pix_3),
        .i_p5     (pix_5),
        .i_p6     (pix_6),
        .i_p7     (pix_7),
        .i_p8     (pix_8),
        .o_abs_gx (w_agx),
        .o_abs_gy (w_agy)
    );

    // ---------------- S3: saturated sum ----------------
    logic [SW-1:0]    w_sum;
    logic [PIX_W-1:0] w_mag;
    logic [PIX_W-1:0] r_mag;

    assign w_sum = SW'(w_agx) + SW'(w_agy);
    assign w_mag = (|w_sum[SW-1:PIX_W]) ? '1 : w_sum[PIX_W-1:0];

    always_ff @(posedge xclk) begin
        if (!rst) begin
            r_mag <= '0;
        end else if (r_pix_en) begin
            r_mag <= w_mag;
        end
    end

    // ---------------- sync / de delay line ----------------
    // de only needs to reach S4's input; syncs run the full latency to the pins.
    logic [SOBEL_LAT-1:0] r_hs_dly;
    logic [SOBEL_LAT-1:0] r_vs_dly;
    logic [SOBEL_LAT-2:0] r_de_dly;
    logic                 w_de_s3;

    always_ff @(posedge xclk) begin
        if (!rst) begin
            r_hs_dly <= '1;
            r_vs_dly <= '1;
            r_de_dly <= '0;
        end else if (r_pix_en) begin
            r_hs_dly <= {r_hs_dly[SOBEL_LAT-2:0], in_hs};
            r_vs_dly <= {r_vs_dly[SOBEL_LAT-2:0], in_vs};
            r_de_dly <= {r_de_dly[SOBEL_LAT-3:0], in_de};
        end
    end

    assign w_de_s3 = r_de_dly[SOBEL_LAT-2];
    assign xhs     = r_hs_dly[SOBEL_LAT-1];
    assign xvs     = r_vs_dly[SOBEL_LAT-1];

    // ---------------- S4: colour output ----------------
    sobel_mode_e          w_mode;
    logic                 w_ge;
    logic [CH_BITS-1:0]   w_chan;
    logic [3*CH_BITS-1:0] r_rgb;

    assign w_mode = sobel_mode_e'(mode);
    assign w_ge   = (r_mag >= thresh);

    always_comb begin
        w_chan = '0;
        if (w_de_s3) begin
            if (w_mode == MODE_GRAY) begin
                w_chan = r_mag[PIX_W-1 -: CH_BITS];
            end else begin
                w_chan = w_ge ? '1 : '0;
            end
        end
    end

    always_ff @(posedge xclk) begin
        if (!rst) begin
            r_rgb <= '0;
        end else if (r_pix_en) begin
            r_rgb <= {3{w_chan}};
        end
    end

    assign xrgb = r_rgb;

`ifdef SOBEL_EDGE_COUNT_EN
    // ---------------- per-frame edge counter ----------------
    logic [19:0] r_edge_cnt;
    logic [19:0] r_edge_count;
    logic        w_edge_hit;
    logic        w_vs_fall;

    assign w_edge_hit = w_de_s3 && w_ge;
    // Stage SOBEL_LAT-2 is the vs value about to appear on xvs this strobe.
    assign w_vs_fall  = r_vs_dly[SOBEL_LAT-1] && !r_vs_dly[SOBEL_LAT-2];

    always_ff @(posedge xclk) begin
        if (!rst) begin
            r_edge_cnt   <= '0;
            r_edge_count <= '0;
        end else if (r_pix_en) begin
            if (w_vs_fall) begin
                r_edge_count <= r_edge_cnt;
                r_edge_cnt   <= {19'd0, w_edge_hit};
            end else if (w_edge_hit && (r_edge_cnt != '1)) begin
                r_edge_cnt <= r_edge_cnt + 20'd1;
            end
        end
    end

    assign edge_count = r_edge_count;
`endif

endmodule

// File: doc/sobel_vga_pipe.md
# sobel_vga_pipe

Parametrised Sobel edge-detection and VGA output pipeline, the successor to the fixed 8-bit, divide-by-2, 2-bit-per-channel Sobel top level. It takes a 3×3 pixel window with sync from the upstream image reader. It generates the pixel-rate strobe that paces that reader, computes a saturated |Gx|+|Gy| magnitude, and drives `xrgb`/`xhs`/`xvs` with syncs delay-matched to the arithmetic pipeline. Output is either grayscale magnitude or a binary threshold.

## Interface
- `PIX_W`, 8: input pixel and magnitude width; legal range 4..12.
- `CLK_DIV`, 2: `xclk` cycles per pixel; legal range 1..16.
- `CH_BITS`, 2: bits per colour channel on `xrgb`; legal range 1..`PIX_W`.

Ports:
- `xclk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-low; clock `xclk`.
- `pix_en`  out  1  one-`xclk` pixel strobe; upstream advances its window on it.
- `pix_0`..`pix_3`, `pix_5`..`pix_8`  in  `PIX_W` each  3×3 window, row-major; `pix_0` is top-left and the centre pixel is unused.
- `in_hs`, `in_vs`  in  1  active-low syncs, aligned with the window.
- `in_de`  in  1  active-video flag, aligned with the window.
- `mode`  in  1  0 = grayscale magnitude, 1 = binary threshold.
- `thresh`  in  `PIX_W`  threshold for mode 1.
- `xrgb`  out  `3*CH_BITS`  output colour, as {R,G,B} with identical channels.
- `xhs`, `xvs`  out  1  delayed syncs.

## Operation
Divider:
- Counter `div_cnt` runs 0..`CLK_DIV`-1 and wraps to 0.
- `pix_en` is registered high for one cycle when `div_cnt`==`CLK_DIV`-1.
- With `CLK_DIV`=1, `pix_en` is high on every cycle after reset.

Pipeline: every stage register loads only when `pix_en`=1 and holds otherwise.
- S1: compute gradients, signed, `PIX_W`+3 bits, no overflow possible.
  - gx = (p2+2p5+p8)−(p0+2p3+p6)
  - gy = (p6+2p7+p8)−(p0+2p1+p2)
- S2: take |gx| and |gy|, unsigned, `PIX_W`+2 bits.
- S3: sum = |gx|+|gy|, then saturate to 2^`PIX_W`−1. Saturation is a hard clamp, not a wrap.
- S4 (output register):
  - If delayed de=0, `xrgb`=0.
  - Else if `mode`=0, each channel = mag[`PIX_W`−1 -: `CH_BITS`].
  - Else each channel = all-ones if mag ≥ `thresh` (inclusive), otherwise 0.

Control inputs and syncs:
- `mode` and `thresh` are sampled at S4 on the same `pix_en` as the result. A change therefore takes effect on the next output pixel, with no glitch.
- `in_hs`, `in_vs` and `in_de` pass through a 4-stage delay line clocked by `pix_en`, so they emerge aligned with `xrgb`.
- No frame-level state exists; behaviour is identical in every frame.

## Timing
- Latency is 4 `pix_en` strobes from window sample to `xrgb`/`xhs`/`xvs` change, i.e. 4·`CLK_DIV` `xclk` cycles.
- Outputs change only on the `xclk` edge where `pix_en`=1 and are stable for `CLK_DIV` cycles.
- Reset values, for all `rst`=0 cycles:
  - `div_cnt`=0, `pix_en`=0, `xrgb`=0.
  - `xhs`=1, `xvs`=1.
  - Sync delay stages = 1, de stages = 0, arithmetic stages = 0.
- First `pix_en` after reset release: `CLK_DIV` cycles after release (for `CLK_DIV`=1, the first cycle after release).
- Reset mid-frame: all state clears on the next edge. Outputs hold reset values until 4 strobes after restart, so no partial stale pixel is emitted.

## Configuration
- `SOBEL_EDGE_COUNT_EN` defined:
  - Adds output port `edge_count` [19:0].
  - An internal counter increments at S4 on each strobe where delayed de=1 and mag ≥ `thresh`, regardless of `mode`. It saturates at 2^20−1.
  - On the strobe where the delayed vs goes 1→0, the counter value is copied to `edge_count` and the counter clears to 0, or to 1 if that same strobe counts an edge.
  - `edge_count` resets to 0.
- Macro undefined: port, counter and logic are absent; all other behaviour is identical.

## Structure
- Package `sobel_pkg` holds:
  - `SOBEL_LAT`=4.
  - Mode constants `MODE_GRAY`=0 and `MODE_THRESH`=1.
  - Default `PIX_W`.
  - The gradient-width function `PIX_W`+3.
- Sub-module `sobel_grad` (S1–S2: window in, |gx| and |gy| out, with an enable input) is natural.
- Divider, S3–S4, delay line and the optional counter stay in the top.

## Test plan
- Reset and divider:
  - Stimulus: `rst`=0 for 5 cycles, then release with `CLK_DIV`=3.
  - Required: `xrgb`=0, `xhs`=`xvs`=1 and `pix_en`=0 throughout reset; after release `pix_en` pulses at cycles 3, 6, 9, …
- Vertical edge:
  - Stimulus: `PIX_W`=8, left column p0,p3,p6=0, right column p2,p5,p8=255, remaining pixels 0, de=1, `mode`=0, `CH_BITS`=2.
  - Required: gx=1020, gy=0 saturates to mag=255, giving `xrgb`=6'b111111 exactly 4 strobes later.
- Gray quantisation:
  - Stimulus: p2=p5=p8=20, all other pixels 0.
  - Required: mag=80=8'b01010000, giving channel value 2'b01 and `xrgb`=6'b010101.
- Threshold boundary:
  - Stimulus: `mode`=1, `thresh`=80 with mag=80, then mag=79.
  - Required: `xrgb`=all-ones, then 0.
- Sync alignment and blanking:
  - Stimulus: pulse `in_hs` low for 1 pixel with de=0 and a nonzero window.
  - Required: `xhs` low exactly 4 strobes later for 1 strobe, with `xrgb`=0 while de=0.
- Edge count, with `SOBEL_EDGE_COUNT_EN` defined:
  - Stimulus: 10 active pixels ≥ `thresh`, then a vs falling edge.
  - Required: `edge_count`=10, with the counter restarting from 0.
